// File: rtl/sys_rst_sequencer.sv
`timescale 1ns/1ps
// Power-on reset sequencer: waits for a stable PLL lock, releases peripherals, then the core.
// Lock loss or a software request drops both resets together; lock losses seen in S_RUN are counted.
module sys_rst_sequencer #(
  parameter int unsigned LOCK_STABLE = 16,
  parameter int unsigned CORE_DLY    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  input  logic       sw_rst_req,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       rst_done,
  output logic [7:0] lock_lost_cnt
);

  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] CORE_LAST   = 16'(CORE_DLY - 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_STABLE = 2'd1,
    S_PERIPH = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lock_s1_q, lock_s1_d;
  logic        lock_s2_q, lock_s2_d;
  logic        periph_rst_n_q, periph_rst_n_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        rst_done_q, rst_done_d;
  logic [7:0]  lock_lost_cnt_q, lock_lost_cnt_d;
  logic        lock_sync;
  logic        lost_event;

  // Two-flop synchronizer; only the second stage feeds the state machine.
  always_comb begin
    lock_s1_d = lock;
    lock_s2_d = lock_s1_q;
  end

  assign lock_sync = lock_s2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lost_event = 1'b0;
    case (state_q)
      S_WAIT: begin
        cnt_d = 16'd0;
        if (lock_sync) begin
          state_d = S_STABLE;
        end
      end
      S_STABLE: begin
        if (!lock_sync) begin
          state_d = S_WAIT;
          cnt_d   = 16'd0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_PERIPH;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PERIPH: begin
        if (!lock_sync) begin
          state_d = S_WAIT;
          cnt_d   = 16'd0;
        end else if (cnt_q == CORE_LAST) begin
          state_d = S_RUN;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        cnt_d = 16'd0;
        // Lock loss wins over a coincident software request so it is counted once.
        if (!lock_sync) begin
          state_d    = S_WAIT;
          lost_event = 1'b1;
        end else if (sw_rst_req) begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Output flops load from the next state so they change on the same edge as the FSM.
  always_comb begin
    periph_rst_n_d  = (state_d == S_PERIPH) || (state_d == S_RUN);
    core_rst_n_d    = (state_d == S_RUN);
    rst_done_d      = (state_d == S_RUN);
    lock_lost_cnt_d = lock_lost_cnt_q;
    if (lost_event && (lock_lost_cnt_q != 8'hFF)) begin
      lock_lost_cnt_d = lock_lost_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_WAIT;
      cnt_q           <= 16'd0;
      lock_s1_q       <= 1'b0;
      lock_s2_q       <= 1'b0;
      periph_rst_n_q  <= 1'b0;
      core_rst_n_q    <= 1'b0;
      rst_done_q      <= 1'b0;
      lock_lost_cnt_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      lock_s1_q       <= lock_s1_d;
      lock_s2_q       <= lock_s2_d;
      periph_rst_n_q  <= periph_rst_n_d;
      core_rst_n_q    <= core_rst_n_d;
      rst_done_q      <= rst_done_d;
      lock_lost_cnt_q <= lock_lost_cnt_d;
    end
  end

  assign periph_rst_n  = periph_rst_n_q;
  assign core_rst_n    = core_rst_n_q;
  assign rst_done      = rst_done_q;
  assign lock_lost_cnt = lock_lost_cnt_q;

endmodule

// File: tb/tb_sys_rst_sequencer.sv
`timescale 1ns/1ps
// Bench for sys_rst_sequencer: fixed vector tables, directed corner sequences,
// then random lock/sw traffic against an edge-count reference model.
module tb_sys_rst_sequencer;

  localparam int LS   = 4;
  localparam int CD   = 3;
  localparam int FULL = LS + 1 + CD;

  logic       clk;
  logic       reset;
  logic       lock;
  logic       sw_rst_req;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       rst_done;
  logic [7:0] lock_lost_cnt;

  int checks;
  int failures;

  // Reference model: age counts qualifying edges since the sequence began;
  // periph is free once age reaches LS+1, core once it reaches LS+1+CD.
  int   m_age;
  int   m_lost;
  logic m_lk[$];

  typedef struct {
    logic       lock;
    logic       sw;
    logic       periph;
    logic       core;
    logic [7:0] lost;
  } vec_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];

  sys_rst_sequencer #(.LOCK_STABLE(LS), .CORE_DLY(CD)) dut (
    .clk           (clk),
    .reset         (reset),
    .lock          (lock),
    .sw_rst_req    (sw_rst_req),
    .periph_rst_n  (periph_rst_n),
    .core_rst_n    (core_rst_n),
    .rst_done      (rst_done),
    .lock_lost_cnt (lock_lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_age  = 0;
    m_lost = 0;
    m_lk   = '{1'b0, 1'b0};
  endtask

  task automatic model_edge(input logic l, input logic s);
    logic sync;
    sync = m_lk[0];
    void'(m_lk.pop_front());
    m_lk.push_back(l);
    if (m_age == 0) begin
      m_age = sync ? 1 : 0;
    end else if (!sync) begin
      if (m_age >= FULL && m_lost < 255) m_lost++;
      m_age = 0;
    end else if (m_age >= FULL) begin
      if (s) m_age = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_model();
    chk("model_periph_rst_n", {7'd0, periph_rst_n}, {7'd0, (m_age >= LS + 1)});
    chk("model_core_rst_n",   {7'd0, core_rst_n},   {7'd0, (m_age >= FULL)});
    chk("model_rst_done",     {7'd0, rst_done},     {7'd0, (m_age >= FULL)});
    chk("model_lock_lost_cnt", lock_lost_cnt, 8'(m_lost));
  endtask

  task automatic apply(input logic l, input logic s);
    lock       = l;
    sw_rst_req = s;
    @(posedge clk);
    model_edge(l, s);
    #1;
    check_model();
    sw_rst_req = 1'b0;
  endtask

  // Asserts reset between edges, checks the asynchronous clear, holds, then releases.
  task automatic do_reset(input int hold);
    reset      = 1'b1;
    lock       = 1'b0;
    sw_rst_req = 1'b0;
    model_reset();
    #1;
    chk("async_rst_periph", {7'd0, periph_rst_n}, 8'd0);
    chk("async_rst_core",   {7'd0, core_rst_n},   8'd0);
    chk("async_rst_done",   {7'd0, rst_done},     8'd0);
    chk("async_rst_lost",   lock_lost_cnt,        8'd0);
    for (int i = 0; i < hold; i++) begin
      lock = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_rst_periph", {7'd0, periph_rst_n}, 8'd0);
      chk("hold_rst_core",   {7'd0, core_rst_n},   8'd0);
    end
    lock  = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run_until_core();
    int n;
    n = 0;
    while (core_rst_n !== 1'b1 && n < 40) begin
      apply(1'b1, 1'b0);
      n++;
    end
    chk("run_until_core_timeout", {7'd0, core_rst_n}, 8'd1);
  endtask

  task automatic run_vectors(input string tag, input vec_t vq[$]);
    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].lock, vq[i].sw);
      chk($sformatf("%s[%0d]_periph", tag, i), {7'd0, periph_rst_n}, {7'd0, vq[i].periph});
      chk($sformatf("%s[%0d]_core", tag, i),   {7'd0, core_rst_n},   {7'd0, vq[i].core});
      chk($sformatf("%s[%0d]_lost", tag, i),   lock_lost_cnt,        vq[i].lost);
    end
  endtask

  initial begin
    vec_t v;
    int   n;
    int   lost_before;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    lock       = 1'b0;
    sw_rst_req = 1'b0;
    model_reset();

    // Steady lock from E0: periph at E6, core at E9.
    for (int k = 0; k < 12; k++) begin
      v.lock = 1'b1; v.sw = 1'b0;
      v.periph = (k >= 6); v.core = (k >= 9); v.lost = 8'd0;
      vecs_a.push_back(v);
    end
    // Glitch: high E0-E1, low E2, high from E3 -> periph at E9, core at E12.
    for (int k = 0; k < 14; k++) begin
      v.lock = (k != 2); v.sw = 1'b0;
      v.periph = (k >= 9); v.core = (k >= 12); v.lost = 8'd0;
      vecs_b.push_back(v);
    end

    #2;
    do_reset(2);
    run_vectors("steady", vecs_a);
    do_reset(2);
    run_vectors("glitch", vecs_b);

    // One-cycle lock drop in S_RUN.
    lost_before = m_lost;
    apply(1'b0, 1'b0);
    apply(1'b1, 1'b0);
    apply(1'b1, 1'b0);
    chk("drop_periph_low", {7'd0, periph_rst_n}, 8'd0);
    chk("drop_core_low",   {7'd0, core_rst_n},   8'd0);
    chk("drop_lost_inc",   lock_lost_cnt,        8'(lost_before + 1));
    n = 0;
    while (periph_rst_n !== 1'b1 && n < 30) begin apply(1'b1, 1'b0); n++; end
    chk("drop_periph_relock_edges", 8'(n), 8'(LS + 1));
    run_until_core();

    // Software reset in S_RUN.
    lost_before = m_lost;
    apply(1'b1, 1'b1);
    chk("sw_periph_low", {7'd0, periph_rst_n}, 8'd0);
    chk("sw_core_low",   {7'd0, core_rst_n},   8'd0);
    chk("sw_lost_same",  lock_lost_cnt,        8'(lost_before));
    n = 0;
    while (periph_rst_n !== 1'b1 && n < 30) begin apply(1'b1, 1'b0); n++; end
    chk("sw_periph_edges", 8'(n), 8'(LS + 1));
    n = 0;
    while (core_rst_n !== 1'b1 && n < 30) begin apply(1'b1, 1'b0); n++; end
    chk("sw_core_edges", 8'(n), 8'(CD));

    // Lock loss coincident with sw_rst_req counts once.
    do_reset(2);
    run_until_core();
    apply(1'b0, 1'b0);
    apply(1'b1, 1'b0);
    apply(1'b1, 1'b1);
    chk("coincident_lost_once", lock_lost_cnt, 8'd1);
    chk("coincident_core_low",  {7'd0, core_rst_n}, 8'd0);

    // Saturation after 300 lock losses.
    for (int i = 0; i < 300; i++) begin
      run_until_core();
      apply(1'b0, 1'b0);
      apply(1'b1, 1'b0);
      apply(1'b1, 1'b0);
    end
    chk("lost_saturated", lock_lost_cnt, 8'd255);

    // Reset between edges while in S_PERIPH.
    do_reset(2);
    n = 0;
    while (periph_rst_n !== 1'b1 && n < 20) begin apply(1'b1, 1'b0); n++; end
    chk("reached_periph", {7'd0, periph_rst_n}, 8'd1);
    chk("periph_core_still_low", {7'd0, core_rst_n}, 8'd0);
    #2;
    do_reset(4);
    run_until_core();

    // Random traffic with occasional resets.
    for (int r = 0; r < 3; r++) begin
      do_reset($urandom_range(1, 3));
      for (int i = 0; i < 1000; i++) begin
        logic l;
        logic s;
        if ($urandom_range(0, 99) < 3) begin
          l = 1'b0;
          for (int j = 0; j < $urandom_range(1, 3); j++) apply(l, 1'b0);
        end
        l = ($urandom_range(0, 29) != 0);
        s = ($urandom_range(0, 19) == 0);
        apply(l, s);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_rst_sequencer.md
SYS_RST_SEQUENCER -- requirements
Module: sys_rst_sequencer

Interface
REQ-001 The block SHALL have parameter LOCK_STABLE, default 16, meaning consecutive synchronized-lock-high cycles required before any release (legal 1..65535).
REQ-002 The block SHALL have parameter CORE_DLY, default 8, meaning cycles between peripheral release and core release (legal 1..65535).
REQ-003 The block SHALL have port clk, input, 1, system clock (PLL system output).
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port lock, input, 1, PLL lock status, asynchronous to clk.
REQ-006 The block SHALL have port sw_rst_req, input, 1, synchronous single-cycle software reset request.
REQ-007 The block SHALL have port periph_rst_n, output, 1, active-low peripheral/bus reset.
REQ-008 The block SHALL have port core_rst_n, output, 1, active-low CPU core reset.
REQ-009 The block SHALL have port rst_done, output, 1, high when the sequence has completed (equals core_rst_n).
REQ-010 The block SHALL have port lock_lost_cnt, output, 8, saturating count of lock losses seen in S_RUN.

Function
REQ-011 The block SHALL synchronize lock through two flops (lock_s1, lock_s2); only lock_s2 (lock_sync) SHALL be used by the state machine.
REQ-012 The block SHALL implement states S_WAIT, S_STABLE, S_PERIPH, S_RUN with a 16-bit counter cnt.
REQ-013 S_WAIT: both resets asserted; lock_sync=1 -> S_STABLE with cnt=0; otherwise stay, cnt=0.
REQ-014 S_STABLE: lock_sync=0 -> S_WAIT; else cnt==LOCK_STABLE-1 -> S_PERIPH with cnt=0; else cnt+1.
REQ-015 S_PERIPH: periph_rst_n=1, core_rst_n=0; lock_sync=0 -> S_WAIT; else cnt==CORE_DLY-1 -> S_RUN; else cnt+1.
REQ-016 S_RUN: both resets deasserted; lock_sync=0 or sw_rst_req=1 -> S_WAIT.
REQ-017 periph_rst_n, core_rst_n, and rst_done SHALL be dedicated flops updated on the same edge as the state transition, with no combinational decode at the outputs.
REQ-018 Timing: with lock rising before edge E0, periph_rst_n SHALL rise at edge E(LOCK_STABLE+2) and core_rst_n at edge E(LOCK_STABLE+2+CORE_DLY).
REQ-019 Any transition to S_WAIT SHALL drive periph_rst_n=0 and core_rst_n=0 on that same edge, with no staged assertion.
REQ-020 lock_lost_cnt SHALL increment by 1 on each S_RUN->S_WAIT transition caused by lock_sync=0, saturating at 255.
REQ-021 If lock_sync=0 and sw_rst_req=1 occur together in S_RUN, this SHALL count as a lock loss, incrementing the count once.
REQ-022 sw_rst_req SHALL be ignored outside S_RUN and SHALL never increment lock_lost_cnt.
REQ-023 A lock glitch shorter than LOCK_STABLE cycles during S_STABLE SHALL restart qualification from S_WAIT with cnt=0.

Reset
REQ-024 Asserting reset SHALL immediately, asynchronously, set state=S_WAIT, cnt=0, lock_s1=lock_s2=0, periph_rst_n=0, core_rst_n=0, rst_done=0, and lock_lost_cnt=0.
REQ-025 On reset release, the block SHALL restart the full sequence from S_WAIT regardless of the lock level.
REQ-026 Reset asserted mid-sequence (S_STABLE/S_PERIPH/S_RUN) SHALL abort with all outputs at their reset values, and lock_lost_cnt SHALL be cleared.

Verification
REQ-027 LOCK_STABLE=4, CORE_DLY=3, lock held high from E0 -> periph_rst_n rises at E6, core_rst_n and rst_done rise at E9, lock_lost_cnt=0.
REQ-028 Lock high for 2 cycles, low for 1, then high steadily (LOCK_STABLE=4) -> no release during the glitch; periph_rst_n rises 6 edges after the final rising edge of lock.
REQ-029 In S_RUN, drop lock for 1 cycle -> both resets low 2 edges later, lock_lost_cnt=1, then full re-sequence -> periph released LOCK_STABLE+2 edges after lock returns.
REQ-030 In S_RUN, pulse sw_rst_req 1 cycle with lock high -> both resets low on the next edge, lock_lost_cnt unchanged, periph rises LOCK_STABLE+1 edges later and core rises CORE_DLY edges after that.
REQ-031 Force 300 lock losses in S_RUN -> lock_lost_cnt holds 255; sw_rst_req coincident with a lock loss -> count incremented once only.
REQ-032 Assert reset during S_PERIPH between clock edges -> periph_rst_n falls without a clock edge, and all outputs hold reset values until release.
